// File: rtl/arbiter_rr_param_pkg.sv
// Shared types and helpers for the parametrised round-robin output arbiter.
package arbiter_pkg;

  // Handshake phase: ARB picks or keeps an owner, WAIT holds RTS until DCTS.
  typedef enum logic {
    ARB  = 1'b0,
    WAIT = 1'b1
  } phase_e;

  // Port index width; never narrower than one bit.
  function automatic int calc_idx_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  // Hold counter width able to store 0..m; never narrower than one bit.
  function automatic int calc_hold_w(input int m);
    return (m > 32'sd0) ? $clog2(m + 32'sd1) : 32'sd1;
  endfunction

  // Index of the set bit of a one-hot vector (0 when the vector is zero).
  function automatic int unsigned onehot_to_idx(input logic [31:0] v);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 0; i < 32; i++) begin
      idx = idx | (v[i] ? unsigned'(i) : 32'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_rr_param_rr_pick.sv
// Cyclic first-one finder: scans i_req starting at i_start, wrapping past the
// top index, and returns the first set request as a one-hot vector.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int IDX_W     = calc_idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_start,
  output logic [NUM_PORTS-1:0] o_win,
  output logic                 o_valid
);

  logic [IDX_W-1:0] w_pos;

  // Walk the ports in cyclic order; the first set request masks all later ones.
  always_comb begin
    o_win   = {NUM_PORTS{1'b0}};
    o_valid = 1'b0;
    w_pos   = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_pos        = IDX_W'((32'(i_start) + unsigned'(i)) % unsigned'(NUM_PORTS));
      o_win[w_pos] = i_req[w_pos] & ~o_valid;
      o_valid      = o_valid | i_req[w_pos];
    end
  end

endmodule

// File: rtl/arbiter_rr_param.sv
// Round-robin output arbiter: picks one of NUM_PORTS requesters, drives the
// one-hot crossbar select and runs the RTS/DCTS handshake downstream.
// rst is asynchronous and active-low.
module arbiter_rr_param
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int MAX_HOLD  = 4,
  parameter int IDX_W     = calc_idx_w(NUM_PORTS),
  parameter int HOLD_W    = calc_hold_w(MAX_HOLD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 rts
);

  logic [NUM_PORTS-1:0] r_owner;
  logic                 r_rts;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [IDX_W-1:0]     r_last_idx;

  logic [NUM_PORTS-1:0] w_owner_nxt;
  logic                 w_rts_nxt;
  logic [HOLD_W-1:0]    w_hold_nxt;
  logic [IDX_W-1:0]     w_last_nxt;

  logic [IDX_W-1:0]     w_start;
  logic [NUM_PORTS-1:0] w_win;
  logic                 w_win_vld;
  logic                 w_hold_ok;
  logic [HOLD_W-1:0]    w_hold_inc;
  logic                 w_stay;
  phase_e               w_phase;

  assign w_phase = r_rts ? WAIT : ARB;

  // Search begins one past the most recently granted port.
  assign w_start = (r_last_idx == IDX_W'(NUM_PORTS - 1)) ? {IDX_W{1'b0}}
                                                         : r_last_idx + IDX_W'(1);

  // With MAX_HOLD of zero an owner may keep the output indefinitely.
  if (MAX_HOLD == 0) begin : g_unlimited
    assign w_hold_ok  = 1'b1;
    assign w_hold_inc = r_hold_cnt;
  end else begin : g_limited
    assign w_hold_ok  = (r_hold_cnt < HOLD_W'(MAX_HOLD));
    assign w_hold_inc = w_hold_ok ? (r_hold_cnt + HOLD_W'(1)) : r_hold_cnt;
  end

  assign w_stay = (|r_owner) && (|(req & r_owner)) && w_hold_ok;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_start (w_start),
    .o_win   (w_win),
    .o_valid (w_win_vld)
  );

  // Next-state logic for owner, handshake and fairness bookkeeping.
  always_comb begin
    w_owner_nxt = r_owner;
    w_rts_nxt   = r_rts;
    w_hold_nxt  = r_hold_cnt;
    w_last_nxt  = r_last_idx;
    case (w_phase)
      ARB: begin
        if (w_stay) begin
          w_rts_nxt = 1'b1;
        end else if (w_win_vld) begin
          w_owner_nxt = w_win;
          w_hold_nxt  = {HOLD_W{1'b0}};
          w_rts_nxt   = 1'b1;
        end else begin
          w_owner_nxt = {NUM_PORTS{1'b0}};
        end
      end
      WAIT: begin
        if (dcts) begin
          w_rts_nxt  = 1'b0;
          w_last_nxt = IDX_W'(onehot_to_idx(32'(r_owner)));
          w_hold_nxt = w_hold_inc;
        end else begin
          w_rts_nxt = 1'b1;
        end
      end
      default: begin
        w_rts_nxt = 1'b0;
      end
    endcase
  end

  // State registers; reset restarts arbitration with port 0 searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= {NUM_PORTS{1'b0}};
      r_rts      <= 1'b0;
      r_hold_cnt <= {HOLD_W{1'b0}};
      r_last_idx <= IDX_W'(NUM_PORTS - 1);
    end else begin
      r_owner    <= w_owner_nxt;
      r_rts      <= w_rts_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_last_idx <= w_last_nxt;
    end
  end

  assign grant    = r_owner & {NUM_PORTS{r_rts & dcts}};
  assign xbar_sel = r_owner;
  assign rts      = r_rts;

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Self-checking bench for arbiter_rr_param: one limited-hold and one
// unlimited-hold instance share stimulus; grants are scored against a queue.
module tb_arbiter_rr_param;

  localparam int NP = 5;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          dcts = 1'b0;
  logic [NP-1:0] req  = 5'b00000;
  logic [NP-1:0] grant, xbar_sel, grant0, xbar_sel0;
  logic          rts, rts0;

  int            total = 0;
  int            bad   = 0;
  logic [NP-1:0] exp_q[$];
  logic [NP-1:0] exp_v;

  // 10-unit clock.
  always #5 clk = ~clk;

  arbiter_rr_param #(.NUM_PORTS(NP), .MAX_HOLD(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dcts     (dcts),
    .grant    (grant),
    .xbar_sel (xbar_sel),
    .rts      (rts)
  );

  arbiter_rr_param #(.NUM_PORTS(NP), .MAX_HOLD(0)) u_dut_unl (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dcts     (dcts),
    .grant    (grant0),
    .xbar_sel (xbar_sel0),
    .rts      (rts0)
  );

  task automatic do_reset;
    @(negedge clk);
    rst  = 1'b0;
    req  = 5'b00000;
    dcts = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    req  = 5'b11111;
    dcts = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++; if (grant !== 5'b00000) begin bad++; $display("FAIL reset_grant: got %b want 00000", grant); end
    total++; if (xbar_sel !== 5'b00000) begin bad++; $display("FAIL reset_xbar: got %b want 00000", xbar_sel); end
    total++; if (rts !== 1'b0) begin bad++; $display("FAIL reset_rts: got %b want 0", rts); end
    @(negedge clk);
    @(negedge clk);
    req = 5'b00000;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if ({rts, xbar_sel, grant} !== 11'd0) begin
        bad++; $display("FAIL reset_idle: cycle %0d got rts=%b xbar=%b grant=%b want all 0", c, rts, xbar_sel, grant);
      end
    end
  endtask

  task automatic test_single;
    do_reset();
    req  = 5'b00100;
    dcts = 1'b1;
    for (int c = 1; c <= 6; c++) exp_q.push_back((c % 2 == 1) ? 5'b00100 : 5'b00000);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++; if (grant !== exp_v) begin bad++; $display("FAIL single_grant: cycle %0d got %b want %b", c, grant, exp_v); end
      total++; if (rts !== exp_v[2]) begin bad++; $display("FAIL single_rts: cycle %0d got %b want %b", c, rts, exp_v[2]); end
      total++; if (xbar_sel !== 5'b00100) begin bad++; $display("FAIL single_xbar: cycle %0d got %b want 00100", c, xbar_sel); end
    end
  endtask

  task automatic test_stall;
    do_reset();
    req  = 5'b00010;
    dcts = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (rts !== 1'b1) begin bad++; $display("FAIL stall_rts: cycle %0d got %b want 1", c, rts); end
      total++; if (xbar_sel !== 5'b00010) begin bad++; $display("FAIL stall_xbar: cycle %0d got %b want 00010", c, xbar_sel); end
      total++; if (grant !== 5'b00000) begin bad++; $display("FAIL stall_grant: cycle %0d got %b want 00000", c, grant); end
    end
    dcts = 1'b1;
    #1;
    total++; if (grant !== 5'b00010) begin bad++; $display("FAIL stall_release_grant: got %b want 00010", grant); end
    @(negedge clk);
    total++; if (rts !== 1'b0) begin bad++; $display("FAIL stall_gap_rts: got %b want 0", rts); end
    total++; if (grant !== 5'b00000) begin bad++; $display("FAIL stall_gap_grant: got %b want 00000", grant); end
    total++; if (xbar_sel !== 5'b00010) begin bad++; $display("FAIL stall_gap_xbar: got %b want 00010", xbar_sel); end
    dcts = 1'b0;
    req  = 5'b00000;
  endtask

  task automatic test_burst;
    int cyc;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back((r == 1) ? 5'b00010 : 5'b00001);
    end
    req  = 5'b00011;
    dcts = 1'b1;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (grant !== 5'b00000) begin
        exp_v = exp_q.pop_front();
        total++; if (grant !== exp_v) begin bad++; $display("FAIL burst_grant: cycle %0d got %b want %b", cyc, grant, exp_v); end
        total++;
        if (($countones(grant) != 1) || ((grant & ~xbar_sel) !== 5'b00000)) begin
          bad++; $display("FAIL burst_onehot: got grant=%b xbar=%b want one-hot subset", grant, xbar_sel);
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL burst_timeout: got %0d grants missing want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_unlimited;
    int cyc;
    logic [NP-1:0] stim [4];
    stim[0] = 5'b00011; stim[1] = 5'b00010; stim[2] = 5'b00100; stim[3] = 5'b11111;
    do_reset();
    dcts = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        repeat (20) exp_q.push_back(5'b00001);
      end else if (s == 3) begin
        exp_q.push_back(5'b01000);
      end else begin
        exp_q.push_back(stim[s]);
      end
      req = stim[s];
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 80) begin
        @(negedge clk);
        cyc++;
        if (grant0 !== 5'b00000) begin
          exp_v = exp_q.pop_front();
          total++; if (grant0 !== exp_v) begin bad++; $display("FAIL unl_grant: step %0d got %b want %b", s, grant0, exp_v); end
        end
      end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL unl_timeout: step %0d got %0d grants missing want 0", s, exp_q.size()); end
      exp_q.delete();
      if (s == 2) begin
        req = 5'b00000;
        @(negedge clk);
        @(negedge clk);
        total++; if ({rts0, xbar_sel0} !== 6'd0) begin bad++; $display("FAIL unl_idle: got rts=%b xbar=%b want 0", rts0, xbar_sel0); end
      end
    end
    req = 5'b00000;
  endtask

  task automatic test_reset_mid_wait;
    int cyc;
    do_reset();
    req  = 5'b11111;
    dcts = 1'b0;
    @(negedge clk);
    total++; if ({rts, xbar_sel} !== 6'b100001) begin bad++; $display("FAIL midwait_pre: got rts=%b xbar=%b want 1/00001", rts, xbar_sel); end
    dcts = 1'b1;
    #1;
    total++; if (grant !== 5'b00001) begin bad++; $display("FAIL midwait_grant: got %b want 00001", grant); end
    #1;
    rst = 1'b0;
    #1;
    total++; if (rts !== 1'b0) begin bad++; $display("FAIL midwait_rts: got %b want 0", rts); end
    total++; if (grant !== 5'b00000) begin bad++; $display("FAIL midwait_grant0: got %b want 00000", grant); end
    total++; if (xbar_sel !== 5'b00000) begin bad++; $display("FAIL midwait_xbar: got %b want 00000", xbar_sel); end
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(5'b00001);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (grant !== 5'b00000) begin
        exp_v = exp_q.pop_front();
        total++; if (grant !== exp_v) begin bad++; $display("FAIL midwait_first: got %b want %b", grant, exp_v); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL midwait_timeout: got %0d grants missing want 0", exp_q.size()); end
    exp_q.delete();
    req  = 5'b00000;
    dcts = 1'b0;
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_single();
    test_stall();
    test_burst();
    test_unlimited();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion before time limit");
    $fatal(1);
  end

endmodule
